// File: rtl/mul_unit.sv
// Iterative radix-2 shift-and-add multiplier / multiply-accumulate (MUL, MLA).
// One multiplier bit is consumed per cycle; result and N/Z flags are registered on completion.
module mul_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             accumulate,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   // Handshake: start is accepted on any edge where the unit is not busy (IDLE or DONE);
   // busy is high for exactly WIDTH cycles, then done pulses for one cycle with result valid.
   // start while busy is dropped, never queued.

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] mcand, mplier, product;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] product_nx;
   logic             load, finish;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      load     = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
               load     = 1'b1;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (count == LAST) begin
               state_nx = DONE;
               finish   = 1'b1;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nx = RUN;
               load     = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Partial sum including this cycle's bit; the final iteration's sum goes straight to result.
   assign product_nx = mplier[0] ? (product + mcand) : product;

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         count   <= '0;
      end else if (load) begin
         mcand   <= a;
         mplier  <= b;
         product <= accumulate ? acc : '0;
         count   <= '0;
      end else if (busy) begin
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         product <= product_nx;
         count   <= count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
         flag_n <= 1'b0;
         flag_z <= 1'b0;
      end else if (finish) begin
         result <= product_nx;
         flag_n <= product_nx[WIDTH-1];
         flag_z <= (product_nx == '0);
      end
   end

   assign state_dbg = state;

endmodule
